// File: rtl/data_mem_pkg.sv
// data_mem_pkg: types and constants shared by the data-memory responder and the CPU memory stage
package data_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int DATA_W = 64;
    // Legal {read, write} encodings; anything else is an illegal op
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b01;
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with write enable and a registered read port
module mem_array import data_mem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [IW-1:0]     idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
    end
    // Only the read register is reset; array contents survive reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    rdata_q <= '0;
        else if (clr_i) rdata_q <= '0;
        else if (re_i)  rdata_q <= mem_q[idx_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency load/store responder for the CPU data-memory port
module data_memory_responder import data_mem_pkg::*; #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] d_in,
    output logic              resp_valid,
    output logic [DATA_W-1:0] d_out,
    output logic              err
);
    localparam int IW = idx_w(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              ld_q, ld_d, ok_q, ok_d, err_q, err_d;
    logic              accept, ok_now, enter;
    assign accept = req_valid && state_q == IDLE;
    assign ok_now = address[2:0] == 3'b000 && (address >> 3) < ADDR_W'(DEPTH)
                    && ({read, write} == OP_LOAD || {read, write} == OP_STORE);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = accept ? address[IW+2:3] : idx_q;
        din_d   = accept ? d_in : din_q;
        ld_d    = accept ? read : ld_q;
        ok_d    = accept ? ok_now : ok_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = LATENCY == 1 ? RESP : WAIT;
                cnt_d   = CW'(LATENCY - 1);
            end
            WAIT: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_d == '0 ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
        err_d = state_d == RESP ? !ok_d : 1'b0;
    end
    assign enter = state_d == RESP;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            din_q   <= '0;
            ld_q    <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            ld_q    <= ld_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end
    // Stores commit as the response cycle completes, so a reset that lands before then discards them
    mem_array #(.DEPTH(DEPTH), .IW(IW)) u_mem (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (state_q == RESP && ok_q && !ld_q),
        .re_i    (enter && ok_d && ld_d),
        .clr_i   (enter && !ok_d),
        .idx_i   (idx_d),
        .wdata_i (din_q),
        .rdata_o (d_out)
    );
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign err        = err_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed table plus multi-cycle sequences over three latency configurations
module tb_data_memory_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  rv = '0;
    logic [2:0]  rdy, rsp, er;
    logic        read = 1'b0, write = 1'b0;
    logic [63:0] address = '0, d_in = '0;
    logic [63:0] dout [3];
    int          checks = 0, errors = 0;
    logic [63:0] r_dout;
    logic        r_err;
    int          r_lat;
    int          lats [3] = '{2, 1, 5};

    always #5 clk = ~clk;

    data_memory_responder #(.LATENCY(2)) u0 (.clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]),
        .read(read), .write(write), .address(address), .d_in(d_in), .resp_valid(rsp[0]), .d_out(dout[0]), .err(er[0]));
    data_memory_responder #(.LATENCY(1)) u1 (.clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]),
        .read(read), .write(write), .address(address), .d_in(d_in), .resp_valid(rsp[1]), .d_out(dout[1]), .err(er[1]));
    data_memory_responder #(.LATENCY(5)) u2 (.clk(clk), .reset(reset), .req_valid(rv[2]), .req_ready(rdy[2]),
        .read(read), .write(write), .address(address), .d_in(d_in), .resp_valid(rsp[2]), .d_out(dout[2]), .err(er[2]));

    typedef struct {
        logic        rd, wr;
        logic [63:0] a, dat, exp_dout;
        logic        exp_err;
    } vec_t;
    vec_t tv [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on DUT d; lat counts falling edges from accept until resp_valid is seen
    task automatic xact(input int d, input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] dat,
                        output logic [63:0] o, output logic e, output int lat);
        int k;
        @(negedge clk);
        read = rd; write = wr; address = a; d_in = dat; rv[d] = 1'b1;
        k = 0;
        while (!rdy[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_accept", 64'(rdy[d]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rv[d] = 1'b0; read = 1'b0; write = 1'b0; address = ~a; d_in = ~dat;
        lat = 0;
        for (k = 1; k <= 20; k++) begin
            chk("ready_low_in_flight", 64'(rdy[d]), 64'd0);
            if (rsp[d]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        o = dout[d];
        e = er[d];
        @(negedge clk);
        chk("resp_one_cycle", 64'(rsp[d]), 64'd0);
        chk("err_idle", 64'(er[d]), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [63:0] acc [4];
        logic seen;
        int k;
        tv[0]  = '{1'b0, 1'b1, 64'h10,  64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 64'h10,  64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 64'h13,  64'h0, 64'h0, 1'b1};
        tv[3]  = '{1'b1, 1'b0, 64'h800, 64'h0, 64'h0, 1'b1};
        tv[4]  = '{1'b1, 1'b0, 64'h10,  64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 64'h08,  64'hAAAA_5555_0000_1111, 64'hDEAD_BEEF_0123_4567, 1'b0};
        tv[6]  = '{1'b1, 1'b1, 64'h08,  64'h1, 64'h0, 1'b1};
        tv[7]  = '{1'b1, 1'b0, 64'h08,  64'h0, 64'hAAAA_5555_0000_1111, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 64'h08,  64'h0, 64'h0, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 64'h7F8, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        tv[10] = '{1'b1, 1'b0, 64'h7F8, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
        tv[11] = '{1'b0, 1'b1, 64'h0,   64'h77, 64'h0123_4567_89AB_CDEF, 1'b0};
        tv[12] = '{1'b0, 1'b1, 64'h800, 64'h5, 64'h0, 1'b1};
        tv[13] = '{1'b1, 1'b0, 64'h0,   64'h0, 64'h77, 1'b0};
        tv[14] = '{1'b1, 1'b0, 64'h8000_0000_0000_0010, 64'h0, 64'h0, 1'b1};
        tv[15] = '{1'b1, 1'b0, 64'h10,  64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", 64'(rdy[d]), 64'd1);
            chk("reset_resp", 64'(rsp[d]), 64'd0);
            chk("reset_dout", dout[d], 64'd0);
        end
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            xact(0, tv[i].rd, tv[i].wr, tv[i].a, tv[i].dat, r_dout, r_err, r_lat);
            chk($sformatf("vec%0d_latency", i), 64'(r_lat), 64'd2);
            chk($sformatf("vec%0d_err", i), 64'(r_err), 64'(tv[i].exp_err));
            chk($sformatf("vec%0d_dout", i), r_dout, tv[i].exp_dout);
        end

        // Asynchronous reset while d_out holds a nonzero load result
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_reset_ready", 64'(rdy[0]), 64'd1);
        chk("async_reset_resp", 64'(rsp[0]), 64'd0);
        chk("async_reset_dout", dout[0], 64'd0);
        chk("async_reset_err", 64'(er[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back stores with req_valid held high
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            read = 1'b0; write = 1'b1; address = 64'h100 + 64'(8 * i); d_in = 64'hB0B0_0000_0000_0000 + 64'(i);
            rv[0] = 1'b1;
            k = 0;
            while (!rdy[0] && k < 50) begin
                @(negedge clk);
                k++;
            end
            @(posedge clk);
            acc[i] = $time;
            @(negedge clk);
            chk("b2b_ready_low", 64'(rdy[0]), 64'd0);
            if (i > 0) chk($sformatf("b2b_spacing%0d", i), acc[i] - acc[i-1], 64'd30);
        end
        rv[0] = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            xact(0, 1'b1, 1'b0, 64'h100 + 64'(8 * i), 64'h0, r_dout, r_err, r_lat);
            chk($sformatf("b2b_read%0d", i), r_dout, 64'hB0B0_0000_0000_0000 + 64'(i));
        end

        // Reset one cycle into a store aborts it on every latency configuration
        for (int d = 0; d < 3; d++) begin
            xact(d, 1'b0, 1'b1, 64'h20, 64'hC0DE_0000_0000_0000 + 64'(d), r_dout, r_err, r_lat);
            chk($sformatf("abort%0d_prestore_lat", d), 64'(r_lat), 64'(lats[d]));
            @(negedge clk);
            read = 1'b0; write = 1'b1; address = 64'h20; d_in = 64'hBAD0_BAD0_BAD0_BAD0; rv[d] = 1'b1;
            k = 0;
            while (!rdy[d] && k < 50) begin
                @(negedge clk);
                k++;
            end
            @(posedge clk);
            #1;
            reset = 1'b0;
            rv[d] = 1'b0;
            #1;
            chk($sformatf("abort%0d_resp_low", d), 64'(rsp[d]), 64'd0);
            @(negedge clk);
            chk($sformatf("abort%0d_ready", d), 64'(rdy[d]), 64'd1);
            reset = 1'b1;
            seen = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (rsp[d]) seen = 1'b1;
            end
            chk($sformatf("abort%0d_no_resp", d), 64'(seen), 64'd0);
            xact(d, 1'b1, 1'b0, 64'h20, 64'h0, r_dout, r_err, r_lat);
            chk($sformatf("abort%0d_load_lat", d), 64'(r_lat), 64'(lats[d]));
            chk($sformatf("abort%0d_load_err", d), 64'(r_err), 64'd0);
            chk($sformatf("abort%0d_load_dout", d), r_dout, 64'hC0DE_0000_0000_0000 + 64'(d));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
